// File: rtl/contador_5bits.sv
// rtl/contador_5bits.sv - run/pause 5-bit counter with synchronised, debounced button controls
// Wraps or saturates at the range ends and flags completion in saturate mode.

module contador_5bits_debounce #(
    parameter int CYC = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);
    localparam int DW = $clog2(CYC + 1);
    localparam logic [DW-1:0] LAST = DW'(CYC - 1);

    logic [DW-1:0] cnt;
    logic          level;
    logic          level_q;

    // The accepted level only moves after CYC consecutive cycles of disagreement;
    // the pulse marks its rising edge one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_q <= level;
            pulse   <= level & ~level_q;
            if (din != level) begin
                if (cnt == LAST) begin
                    level <= din;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + DW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module contador_5bits #(
    parameter int DIV_TICK     = 50000000,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int MAX_VAL      = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       botao_start,
    input  logic       botao_zera,
    input  logic       sentido,
    input  logic       modo_parada,
    output logic [4:0] S,
    output logic       contando,
    output logic       fim
);
    localparam int PW = $clog2(DIV_TICK);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV_TICK - 1);
    localparam logic [4:0]    MAXV     = 5'(MAX_VAL);

    typedef enum logic [1:0] {
        PARADO   = 2'd0,
        CONTANDO = 2'd1,
        FIM      = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic          ev_start;
    logic          ev_zera;
    logic          tick;
    logic [4:0]    cnt_next;
    logic          hit_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {modo_parada, sentido, botao_zera, botao_start};
            sync2 <= sync1;
        end
    end

    contador_5bits_debounce #(.CYC(DEBOUNCE_CYC)) u_db_start (
        .clk   (clk),
        .reset (reset),
        .din   (sync2[0]),
        .pulse (ev_start)
    );

    contador_5bits_debounce #(.CYC(DEBOUNCE_CYC)) u_db_zera (
        .clk   (clk),
        .reset (reset),
        .din   (sync2[1]),
        .pulse (ev_zera)
    );

    assign tick = (state == CONTANDO) && (presc == PRE_LAST);

    // sync2[2] = count down, sync2[3] = saturate
    always_comb begin
        cnt_next = S;
        hit_end  = 1'b0;
        if (!sync2[2]) begin
            if (!sync2[3]) begin
                cnt_next = (S == MAXV) ? 5'd0 : S + 5'd1;
            end else if (S == MAXV) begin
                hit_end = 1'b1;
            end else begin
                cnt_next = S + 5'd1;
                hit_end  = ((S + 5'd1) == MAXV);
            end
        end else begin
            if (!sync2[3]) begin
                cnt_next = (S == 5'd0) ? MAXV : S - 5'd1;
            end else if (S == 5'd0) begin
                hit_end = 1'b1;
            end else begin
                cnt_next = S - 5'd1;
                hit_end  = (S == 5'd1);
            end
        end
    end

    // Clear wins over start and tick; the prescaler only advances while counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= PARADO;
            S     <= 5'd0;
            presc <= '0;
        end else if (ev_zera) begin
            state <= PARADO;
            S     <= 5'd0;
            presc <= '0;
        end else begin
            case (state)
                PARADO: begin
                    if (ev_start) begin
                        state <= CONTANDO;
                        presc <= '0;
                    end
                end
                CONTANDO: begin
                    if (ev_start) begin
                        state <= PARADO;
                    end else if (tick) begin
                        presc <= '0;
                        S     <= cnt_next;
                        if (hit_end) begin
                            state <= FIM;
                        end
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                FIM: begin
                end
                default: state <= PARADO;
            endcase
        end
    end

    assign contando = (state == CONTANDO);
    assign fim      = (state == FIM);
endmodule

// File: tb/tb_contador_5bits.sv
// tb/tb_contador_5bits.sv - scoreboard bench for contador_5bits
// Two instances (MAX_VAL 31 and 9) share stimulus; a behavioural model feeds a queue a monitor drains.

module tb_contador_5bits;
    localparam int DIV = 4;
    localparam int DEB = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       botao_start = 1'b0;
    logic       botao_zera = 1'b0;
    logic       sentido = 1'b0;
    logic       modo_parada = 1'b0;
    logic [4:0] s31, s9;
    logic       contando31, fim31, contando9, fim9;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    contador_5bits #(.DIV_TICK(DIV), .DEBOUNCE_CYC(DEB), .MAX_VAL(31)) dut31 (
        .clk(clk), .reset(reset), .botao_start(botao_start), .botao_zera(botao_zera),
        .sentido(sentido), .modo_parada(modo_parada),
        .S(s31), .contando(contando31), .fim(fim31)
    );

    contador_5bits #(.DIV_TICK(DIV), .DEBOUNCE_CYC(DEB), .MAX_VAL(9)) dut9 (
        .clk(clk), .reset(reset), .botao_start(botao_start), .botao_zera(botao_zera),
        .sentido(sentido), .modo_parada(modo_parada),
        .S(s9), .contando(contando9), .fim(fim9)
    );

    // mode: 0 idle, 1 running, 2 finished; phase counts clocks into the current tick period
    typedef struct {
        logic [3:0] raw_prev;
        logic [3:0] raw_prev2;
        int  run_s, run_z;
        bit  db_s, db_z, db_old_s, db_old_z, ev_s, ev_z;
        int  mode;
        int  count;
        int  phase;
    } model_t;

    model_t m31, m9;
    logic [13:0] exp_q[$];

    function automatic model_t model_reset();
        model_t r;
        r = '{default: 0};
        return r;
    endfunction

    function automatic model_t model_step(model_t m, logic [3:0] raw, int maxv);
        logic [3:0] sy;
        bit evs, evz, down, sat;
        sy = m.raw_prev2;
        m.raw_prev2 = m.raw_prev;
        m.raw_prev  = raw;
        evs = m.ev_s;
        evz = m.ev_z;
        down = sy[2];
        sat  = sy[3];
        m.ev_s = m.db_s && !m.db_old_s;
        m.ev_z = m.db_z && !m.db_old_z;
        m.db_old_s = m.db_s;
        m.db_old_z = m.db_z;
        if (sy[0] != m.db_s) begin
            m.run_s++;
            if (m.run_s == DEB) begin m.db_s = sy[0]; m.run_s = 0; end
        end else m.run_s = 0;
        if (sy[1] != m.db_z) begin
            m.run_z++;
            if (m.run_z == DEB) begin m.db_z = sy[1]; m.run_z = 0; end
        end else m.run_z = 0;

        if (evz) begin
            m.mode = 0; m.count = 0; m.phase = 0;
        end else if (m.mode == 0) begin
            if (evs) begin m.mode = 1; m.phase = 0; end
        end else if (m.mode == 1) begin
            if (evs) m.mode = 0;
            else if (m.phase == DIV - 1) begin
                m.phase = 0;
                if (!sat) begin
                    if (!down) m.count = (m.count + 1) % (maxv + 1);
                    else       m.count = (m.count + maxv) % (maxv + 1);
                end else if (!down) begin
                    if (m.count == maxv) m.mode = 2;
                    else begin m.count++; if (m.count == maxv) m.mode = 2; end
                end else begin
                    if (m.count == 0) m.mode = 2;
                    else begin m.count--; if (m.count == 0) m.mode = 2; end
                end
            end else m.phase++;
        end
        return m;
    endfunction

    function automatic logic [6:0] model_out(model_t m);
        return {5'(m.count), m.mode == 1, m.mode == 2};
    endfunction

    task automatic cyc();
        @(posedge clk);
        if (reset) begin
            m31 = model_reset();
            m9  = model_reset();
        end else begin
            m31 = model_step(m31, {modo_parada, sentido, botao_zera, botao_start}, 31);
            m9  = model_step(m9,  {modo_parada, sentido, botao_zera, botao_start}, 9);
        end
        exp_q.push_back({model_out(m31), model_out(m9)});
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic press_start(int n);
        botao_start = 1'b1;
        idle(n);
        botao_start = 1'b0;
        idle(4);
    endtask

    task automatic press_zera(int n);
        botao_zera = 1'b1;
        idle(n);
        botao_zera = 1'b0;
        idle(4);
    endtask

    task automatic mid_reset();
        cyc();
        #2;
        reset = 1'b1;
        m31 = model_reset();
        m9  = model_reset();
        exp_q.delete();
        exp_q.push_back({model_out(m31), model_out(m9)});
        #1;
        checks++;
        if ({s31, contando31, fim31, s9, contando9, fim9} !== 14'd0) begin
            errors++;
            $display("FAIL async_reset: got S31=%0d c=%0b f=%0b S9=%0d c=%0b f=%0b, expected all zero",
                     s31, contando31, fim31, s9, contando9, fim9);
        end
        idle(2);
        reset = 1'b0;
    endtask

    initial begin : monitor
        logic [13:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks += 2;
                if ({s31, contando31, fim31} !== e[13:7]) begin
                    errors++;
                    $display("FAIL dut31 at %0t: got S=%0d contando=%0b fim=%0b, expected S=%0d contando=%0b fim=%0b",
                             $time, s31, contando31, fim31, e[13:9], e[8], e[7]);
                end
                if ({s9, contando9, fim9} !== e[6:0]) begin
                    errors++;
                    $display("FAIL dut9 at %0t: got S=%0d contando=%0b fim=%0b, expected S=%0d contando=%0b fim=%0b",
                             $time, s9, contando9, fim9, e[6:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin : driver
        m31 = model_reset();
        m9  = model_reset();
        idle(3);
        reset = 1'b0;
        idle(2);

        // start held, then free-running up/wrap long enough to wrap both instances
        press_start(10);
        idle(150);
        sentido = 1'b1;
        idle(80);

        // saturate up: MAX 9 instance finishes, start presses are ignored there
        press_zera(5);
        sentido = 1'b0;
        modo_parada = 1'b1;
        press_start(5);
        idle(60);
        press_start(5);
        modo_parada = 1'b0;
        idle(10);
        press_zera(5);

        // saturate down from zero finishes on the first tick
        sentido = 1'b1;
        modo_parada = 1'b1;
        press_start(5);
        idle(10);
        press_zera(5);
        sentido = 1'b0;
        modo_parada = 1'b0;

        // glitches shorter than the debounce window
        for (int i = 0; i < 5; i++) begin
            botao_start = 1'b1; idle(2);
            botao_start = 1'b0; idle(1);
        end
        idle(10);
        press_start(6);
        idle(6);

        // pause and resume
        press_start(4);
        idle(20);
        press_start(4);
        idle(12);

        // start and clear accepted together
        botao_start = 1'b1;
        botao_zera  = 1'b1;
        idle(5);
        botao_start = 1'b0;
        botao_zera  = 1'b0;
        idle(6);

        press_start(5);
        idle(3);
        mid_reset();
        idle(5);

        for (int k = 0; k < 400; k++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 6)        press_start($urandom_range(1, 8));
            else if (r == 6)  press_zera($urandom_range(1, 6));
            else if (r == 7)  sentido = ~sentido;
            else if (r == 8)  modo_parada = ~modo_parada;
            else if (r == 9 && $urandom_range(0, 9) == 0) mid_reset();
            else              idle($urandom_range(1, 40));
            if ($urandom_range(0, 3) == 0) begin
                botao_start = 1'($urandom_range(0, 1));
                idle(1);
                botao_start = 1'b0;
            end
        end

        idle(2);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
